sat_alu16: RTL and testbench

- 16-bit ALU with a registered result for the processor execute stage.
- Supports saturating signed add/subtract, XOR, byte reduction, shifts/rotate and nibble-wise saturating add (PADDSB).
- Computes combinationally from A, B and opcode, then registers result and flags on the rising clock edge.

---
 rtl/sat_alu16_if.sv | 22 ++
 rtl/sat_alu16.sv | 129 ++++++++++++
 tb/tb_sat_alu16.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sat_alu16_if.sv
// Operand/result bundle for the sat_alu16 execute-stage ALU.
// The master drives operands and the opcode; the slave (the ALU)
// returns the registered result and flags.
interface sat_alu16_if;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  opcode;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    modport master (
        output A, B, opcode,
        input  result, flag_z, flag_v, flag_n
    );

    modport slave (
        input  A, B, opcode,
        output result, flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/sat_alu16.sv
// 16-bit execute-stage ALU: saturating add/sub, XOR, byte reduction,
// shifts/rotate and nibble-wise saturating add. The result and flags are
// computed combinationally and registered on the rising edge of clk.
module sat_alu16 #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    sat_alu16_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_XOR    = 3'b010,
        OP_RED    = 3'b011,
        OP_SLL    = 3'b100,
        OP_SRA    = 3'b101,
        OP_ROR    = 3'b110,
        OP_PADDSB = 3'b111
    } op_e;

    op_e         op;
    logic [3:0]  amt;
    logic [15:0] add_sum;
    logic [15:0] sub_diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic [9:0]  red_sum;
    logic [15:0] ror_res;
    logic [15:0] paddsb_res;

    logic [15:0] result_d, result_q;
    logic        flag_z_d, flag_z_q;
    logic        flag_v_d, flag_v_q;
    logic        flag_n_d, flag_n_q;

    assign op  = op_e'(bus.opcode);
    // Only the low four bits of B set the shift/rotate distance.
    assign amt = bus.B[3:0];

    // Signed overflow: operands agree in sign (add) or differ (sub) and the
    // wrapped result's sign disagrees with A.
    assign add_sum  = bus.A + bus.B;
    assign sub_diff = bus.A - bus.B;
    assign add_ovf  = (bus.A[15] == bus.B[15]) && (add_sum[15]  != bus.A[15]);
    assign sub_ovf  = (bus.A[15] != bus.B[15]) && (sub_diff[15] != bus.A[15]);

    // Four bytes of at most 0xFF sum to at most 0x3FC, so 10 bits suffice.
    assign red_sum = {2'b00, bus.A[15:8]} + {2'b00, bus.A[7:0]}
                   + {2'b00, bus.B[15:8]} + {2'b00, bus.B[7:0]};

    // A left shift by 16 (amt == 0) yields zero, so rotate-by-0 returns A.
    assign ror_res = (bus.A >> amt) | (bus.A << (5'd16 - {1'b0, amt}));

    // Nibble lanes add independently; each clamps to 0x7/0x8 on overflow.
    always_comb begin
        logic [3:0] lane_a;
        logic [3:0] lane_b;
        logic [3:0] lane_s;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        paddsb_res = '0;
        lane_a     = '0;
        lane_b     = '0;
        lane_s     = '0;
        for (int i = 0; i < 4; i++) begin
            lane_a = bus.A[i*4 +: 4];
            lane_b = bus.B[i*4 +: 4];
            lane_s = lane_a + lane_b;
            if ((lane_a[3] == lane_b[3]) && (lane_s[3] != lane_a[3])) begin
                lane_s = lane_a[3] ? 4'h8 : 4'h7;
            end
            paddsb_res[i*4 +: 4] = lane_s;
        end
    end

    // Select the next result; V/N change only on ADD/SUB, Z on every op.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later statements see
        // earlier values within the same evaluation.
        result_d = '0;
        flag_v_d = flag_v_q;
        flag_n_d = flag_n_q;
        unique case (op)
            OP_ADD: begin
                result_d = add_ovf ? (bus.A[15] ? 16'h8000 : 16'h7FFF) : add_sum;
                flag_v_d = add_ovf;
                flag_n_d = result_d[15];
            end
            OP_SUB: begin
                result_d = sub_ovf ? (bus.A[15] ? 16'h8000 : 16'h7FFF) : sub_diff;
                flag_v_d = sub_ovf;
                flag_n_d = result_d[15];
            end
            OP_XOR:    result_d = bus.A ^ bus.B;
            OP_RED:    result_d = {6'b000000, red_sum};
            OP_SLL:    result_d = bus.A << amt;
            OP_SRA:    result_d = 16'($signed(bus.A) >>> amt);
            OP_ROR:    result_d = ror_res;
            OP_PADDSB: result_d = paddsb_res;
            default:   result_d = '0;
        endcase
        flag_z_d = (result_d == 16'h0000);
    end

    // Output register with synchronous reset taking priority over any op.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so all registers
        // update together from values sampled at the same edge.
        if (rst) begin
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            result_q <= result_d;
            flag_z_q <= flag_z_d;
            flag_v_q <= flag_v_d;
            flag_n_q <= flag_n_d;
        end
    end

    assign bus.result = result_q;
    assign bus.flag_z = flag_z_q;
    assign bus.flag_v = flag_v_q;
    assign bus.flag_n = flag_n_q;

endmodule

// File: tb/tb_sat_alu16.sv
// Self-checking bench for sat_alu16: directed boundary cases plus
// incrementing and random sweeps against an arithmetic reference model.
module tb_sat_alu16;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic model_v;
    logic model_n;

    sat_alu16_if bus ();

    sat_alu16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic rules, using plain integers.
    function automatic void ref_model(input logic [2:0] op, input logic [15:0] a,
                                      input logic [15:0] b, output logic [15:0] r,
                                      output logic sat);
        int sa, sb, s, n, ua, ub, acc, la, lb, ls;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        ua  = int'(a);
        ub  = int'(b);
        n   = int'(b[3:0]);
        sat = 1'b0;
        r   = 16'h0000;
        case (op)
            3'd0, 3'd1: begin
                s = (op == 3'd0) ? sa + sb : sa - sb;
                if (s > 32767) begin s = 32767; sat = 1'b1; end
                if (s < -32768) begin s = -32768; sat = 1'b1; end
                r = 16'(s);
            end
            3'd2: r = a ^ b;
            3'd3: r = 16'((ua / 256) + (ua % 256) + (ub / 256) + (ub % 256));
            3'd4: r = 16'((ua * (1 << n)) % 65536);
            3'd5: r = 16'(sa >>> n);
            3'd6: r = 16'(((ua * 65536 + ua) >> n) % 65536);
            default: begin
                acc = 0;
                for (int i = 0; i < 4; i++) begin
                    la = (ua >> (4 * i)) % 16;
                    lb = (ub >> (4 * i)) % 16;
                    if (la >= 8) la = la - 16;
                    if (lb >= 8) lb = lb - 16;
                    ls = la + lb;
                    if (ls > 7) ls = 7;
                    if (ls < -8) ls = -8;
                    acc = acc + (((ls + 16) % 16) << (4 * i));
                end
                r = 16'(acc);
            end
        endcase
    endfunction

    // One operation per cycle: drive at negedge, check just after posedge.
    task automatic do_op(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input string tag);
        logic [15:0] exp_r;
        logic        sat;
        @(negedge clk);
        rst        = 1'b0;
        bus.opcode = op;
        bus.A      = a;
        bus.B      = b;
        ref_model(op, a, b, exp_r, sat);
        if (op == 3'd0 || op == 3'd1) begin
            model_v = sat;
            model_n = exp_r[15];
        end
        @(posedge clk);
        #1;
        check({tag, ".result"}, bus.result, exp_r);
        check({tag, ".z"}, {15'd0, bus.flag_z}, {15'd0, exp_r == 16'h0000});
        check({tag, ".v"}, {15'd0, bus.flag_v}, {15'd0, model_v});
        check({tag, ".n"}, {15'd0, bus.flag_n}, {15'd0, model_n});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst        = 1'b1;
        bus.opcode = 3'd0;
        bus.A      = 16'h7FFF;
        bus.B      = 16'h0001;
        @(posedge clk);
        #1;
        model_v = 1'b0;
        model_n = 1'b0;
        check({tag, ".result"}, bus.result, 16'h0000);
        check({tag, ".flags"}, {13'd0, bus.flag_z, bus.flag_v, bus.flag_n}, 16'h0000);
    endtask

    initial begin
        logic [15:0] a_inc;
        logic [15:0] b_inc;
        tests_run    = 0;
        tests_failed = 0;
        model_v      = 1'b0;
        model_n      = 1'b0;
        rst          = 1'b1;
        bus.A        = '0;
        bus.B        = '0;
        bus.opcode   = '0;

        do_reset("reset0");

        // ADD/SUB saturation and flag hold
        do_op(3'd0, 16'h7FFF, 16'h0001, "add_pos_sat");
        check("add_pos_sat.const", bus.result, 16'h7FFF);
        do_op(3'd1, 16'h8000, 16'h0001, "sub_neg_sat");
        check("sub_neg_sat.const", bus.result, 16'h8000);
        do_op(3'd0, 16'h0003, 16'hFFFD, "add_zero");
        do_op(3'd1, 16'h8000, 16'h0001, "sub_neg_sat2");
        do_op(3'd2, 16'h00FF, 16'h0F0F, "xor_hold");
        check("xor_hold.const", bus.result, 16'h0FF0);
        do_op(3'd0, 16'h7FFF, 16'h7FFF, "add_max_max");
        do_op(3'd1, 16'h7FFF, 16'h8000, "sub_max_min");
        do_op(3'd0, 16'h8000, 16'h8000, "add_min_min");

        // Reset while flags are set clears them and beats the pending op
        do_reset("reset_mid");

        // PADDSB
        do_op(3'd7, 16'h7777, 16'h1111, "paddsb_pos");
        check("paddsb_pos.const", bus.result, 16'h7777);
        do_op(3'd7, 16'h8888, 16'hFFFF, "paddsb_neg");
        do_op(3'd7, 16'h1234, 16'h1111, "paddsb_plain");
        check("paddsb_plain.const", bus.result, 16'h2345);
        do_op(3'd7, 16'h7F18, 16'h18F7, "paddsb_mixed");

        // RED
        do_op(3'd3, 16'h0102, 16'h0304, "red_small");
        check("red_small.const", bus.result, 16'h000A);
        do_op(3'd3, 16'hFFFF, 16'hFFFF, "red_max");
        check("red_max.const", bus.result, 16'h03FC);

        // Shifts and rotate
        do_op(3'd4, 16'h0001, 16'h000F, "sll_15");
        check("sll_15.const", bus.result, 16'h8000);
        do_op(3'd5, 16'h8000, 16'h000F, "sra_15");
        check("sra_15.const", bus.result, 16'hFFFF);
        do_op(3'd5, 16'h4000, 16'h0002, "sra_2");
        do_op(3'd6, 16'h3BCA, 16'h0005, "ror_5");
        check("ror_5.const", bus.result, 16'h51DE);
        do_op(3'd6, 16'hA5C3, 16'h0000, "ror_0");
        check("ror_0.const", bus.result, 16'hA5C3);
        do_op(3'd4, 16'h0F0F, 16'hFFF3, "sll_hi_ignored");
        do_op(3'd5, 16'h8F00, 16'hFFF3, "sra_hi_ignored");
        do_op(3'd6, 16'h1234, 16'hFFF3, "ror_hi_ignored");
        do_op(3'd4, 16'hBEEF, 16'h0000, "sll_0");

        // Incrementing sweep across every opcode
        a_inc = 16'h7FF0;
        b_inc = 16'h0003;
        for (int i = 0; i < 512; i++) begin
            do_op(3'(i % 8), a_inc, b_inc, "sweep_inc");
            a_inc = a_inc + 16'h0101;
            b_inc = b_inc + 16'h0457;
        end

        // Random sweep
        for (int i = 0; i < 1024; i++) begin
            do_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), "sweep_rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
